// File: rtl/clk_cfg_pkg.sv
// Shared types and defaults for the clock-configuration sequencer.
package clk_cfg_pkg;

  typedef enum logic [1:0] {
    SRC_8M   = 2'd0,
    SRC_XCLK = 2'd1,
    SRC_ROSC = 2'd2
  } src_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PARK   = 3'd1,
    MUX    = 3'd2,
    SWITCH = 3'd3,
    DIV    = 3'd4
  } state_e;

  localparam int unsigned DEF_SETTLE_CYC  = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  // Reserved code 3 parks on 8 MHz; xclk is refused while the loss fault is pending.
  function automatic src_e eff_src(input logic [1:0] src, input logic fault);
    src_e r;
    case (src)
      2'd1:    r = fault ? SRC_8M : SRC_XCLK;
      2'd2:    r = SRC_ROSC;
      default: r = SRC_8M;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xclk_watchdog.sv
// xclk heartbeat loss detector: 2-flop synchronizer, toggle edge detect and
// a saturating idle counter that pulses timeout when it reaches TIMEOUT_CYC.
module xclk_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic hb,
  output logic timeout
);

  localparam logic [9:0] LIMIT = 10'(TIMEOUT_CYC);

  logic [2:0] sync_q;
  logic [9:0] cnt_q;
  logic [9:0] cnt_d;
  logic       edge_s;

  // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized value.
  assign edge_s = sync_q[2] ^ sync_q[1];

  // Pulse on the cycle the counter is about to reach the limit.
  assign timeout = arm && !edge_s && (cnt_q == (LIMIT - 10'd1));

  always_comb begin
    if (!arm || edge_s) begin
      cnt_d = 10'd0;
    end else if (cnt_q == LIMIT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
      cnt_q  <= 10'd0;
    end else begin
      sync_q <= {sync_q[1:0], hb};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_cfg_seq.sv
// Glitch-safe clock source/divider sequencer: park on 8 MHz, move the mux,
// switch over, then change the divider; falls back to 8 MHz on xclk loss.
module clk_cfg_seq
  import clk_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_rosc,
  input  logic [1:0] req_div,
  input  logic       xclk_hb,
  input  logic       fault_clr,
  output logic       sel_n_8mhz,
  output logic       sel_xclk,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div,
  output logic       busy,
  output logic       xclk_fault
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  src_e       src_q, src_d;
  logic [1:0] rosc_q, rosc_d;
  logic [1:0] div_q, div_d;
  logic       seln_q, seln_d;
  logic       selx_q, selx_d;
  logic [1:0] selr_q, selr_d;
  logic [1:0] clkdiv_q, clkdiv_d;
  logic       fault_q, fault_d;
  logic       ready_q, ready_d;

  logic accept_s;
  logic step_done_s;
  logic alt_s;
  logic timeout_s;

  assign accept_s    = req_valid && ready_q;
  assign step_done_s = (cnt_q == SETTLE_LAST);
  assign alt_s       = (src_q != SRC_8M);

  xclk_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .arm    (seln_q && selx_q),
    .hb     (xclk_hb),
    .timeout(timeout_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      src_q    <= SRC_8M;
      rosc_q   <= 2'd0;
      div_q    <= 2'd0;
      seln_q   <= 1'b0;
      selx_q   <= 1'b0;
      selr_q   <= 2'd0;
      clkdiv_q <= 2'd0;
      fault_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      rosc_q   <= rosc_d;
      div_q    <= div_d;
      seln_q   <= seln_d;
      selx_q   <= selx_d;
      selr_q   <= selr_d;
      clkdiv_q <= clkdiv_d;
      fault_q  <= fault_d;
      ready_q  <= ready_d;
    end
  end

  // Each step holds for SETTLE_CYC cycles; src 8 MHz skips the SWITCH wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        cnt_d   = 8'd0;
        state_d = accept_s ? PARK : IDLE;
      end
      PARK: begin
        if (step_done_s) begin
          state_d = MUX;
          cnt_d   = 8'd0;
        end else begin
          state_d = PARK;
        end
      end
      MUX: begin
        if (step_done_s) begin
          state_d = alt_s ? SWITCH : DIV;
          cnt_d   = 8'd0;
        end else begin
          state_d = MUX;
        end
      end
      SWITCH: begin
        if (step_done_s) begin
          state_d = DIV;
          cnt_d   = 8'd0;
        end else begin
          state_d = SWITCH;
        end
      end
      DIV: begin
        if (step_done_s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          state_d = DIV;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (timeout_s && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Output values are applied on the edge that enters each step.
  always_comb begin
    src_d    = src_q;
    rosc_d   = rosc_q;
    div_d    = div_q;
    seln_d   = seln_q;
    selx_d   = selx_q;
    selr_d   = selr_q;
    clkdiv_d = clkdiv_q;
    if (timeout_s) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          src_d  = eff_src(req_src, fault_d);
          rosc_d = req_rosc;
          div_d  = req_div;
          seln_d = 1'b0;
        end else begin
          seln_d = seln_q;
        end
      end
      PARK: begin
        if (step_done_s) begin
          selx_d = (src_q == SRC_XCLK);
          selr_d = (src_q == SRC_ROSC) ? rosc_q : selr_q;
        end else begin
          selx_d = selx_q;
        end
      end
      MUX: begin
        if (step_done_s && alt_s) begin
          seln_d = 1'b1;
        end else if (step_done_s) begin
          clkdiv_d = div_q;
        end else begin
          seln_d = seln_q;
        end
      end
      SWITCH: begin
        if (step_done_s) begin
          clkdiv_d = div_q;
        end else begin
          clkdiv_d = clkdiv_q;
        end
      end
      DIV:     clkdiv_d = clkdiv_q;
      default: clkdiv_d = clkdiv_q;
    endcase
    // xclk loss overrides any step in progress; the divider is kept.
    if (timeout_s) begin
      seln_d = 1'b0;
      selx_d = 1'b0;
    end else begin
      selx_d = selx_d;
    end
    ready_d = (state_d == IDLE);
  end

  assign req_ready  = ready_q;
  assign busy       = !ready_q;
  assign sel_n_8mhz = seln_q;
  assign sel_xclk   = selx_q;
  assign sel_rosc   = selr_q;
  assign clk_div    = clkdiv_q;
  assign xclk_fault = fault_q;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Bench for clk_cfg_seq: directed checks with hand-computed expectations plus
// randomized traffic compared every cycle against a schedule-based model.
module tb_clk_cfg_seq;

  localparam int S = 16;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_src = 2'd0;
  logic [1:0] req_rosc = 2'd0;
  logic [1:0] req_div = 2'd0;
  logic       xclk_hb = 1'b0;
  logic       fault_clr = 1'b0;
  logic       req_ready, sel_n_8mhz, sel_xclk, busy, xclk_fault;
  logic [1:0] sel_rosc, clk_div;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit hb_en = 1'b0;

  clk_cfg_seq #(
    .SETTLE_CYC (S),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_rosc  (req_rosc),
    .req_div   (req_div),
    .xclk_hb   (xclk_hb),
    .fault_clr (fault_clr),
    .sel_n_8mhz(sel_n_8mhz),
    .sel_xclk  (sel_xclk),
    .sel_rosc  (sel_rosc),
    .clk_div   (clk_div),
    .busy      (busy),
    .xclk_fault(xclk_fault)
  );

  always #5 clk = ~clk;

  // Reference model: a request is a timeline of changes at S, 2S, 3S, 4S
  // cycles after acceptance; the watchdog is "T cycles since arming or since
  // the last synchronized heartbeat toggle".
  int         cyc = 0;
  int         t0 = 0;
  int         wd_ref = 0;
  logic       m_seln, m_selx, m_fault, m_busy;
  logic [1:0] m_selr, m_div, m_src, m_rosc, m_rdiv;
  logic [2:0] hq;

  always @(posedge clk) begin : model
    logic armed_pre, clr, tmo, busy_pre, alt;
    int el;
    cyc++;
    if (rst) begin
      m_seln = 1'b0; m_selx = 1'b0; m_selr = 2'd0; m_div = 2'd0;
      m_fault = 1'b0; m_busy = 1'b0; hq = 3'b000; wd_ref = 0;
    end else begin
      armed_pre = m_seln && m_selx;
      clr = (hq[1] != hq[2]);
      tmo = armed_pre && !clr && ((cyc - wd_ref) == T);
      busy_pre = m_busy;
      if (tmo) m_fault = 1'b1;
      else if (fault_clr) m_fault = 1'b0;
      if (tmo) begin
        m_seln = 1'b0; m_selx = 1'b0; m_busy = 1'b0;
      end
      if (!busy_pre) begin
        if (req_valid) begin
          m_busy = 1'b1; t0 = cyc; m_seln = 1'b0;
          m_rosc = req_rosc; m_rdiv = req_div;
          m_src = ((req_src == 2'd3) || ((req_src == 2'd1) && m_fault)) ? 2'd0 : req_src;
        end
      end else if (m_busy) begin
        el = cyc - t0;
        alt = (m_src != 2'd0);
        if (el == S) begin
          m_selx = (m_src == 2'd1);
          if (m_src == 2'd2) m_selr = m_rosc;
        end
        if (el == 2 * S) begin
          if (alt) m_seln = 1'b1;
          else m_div = m_rdiv;
        end
        if (el == 3 * S) begin
          if (alt) m_div = m_rdiv;
          else m_busy = 1'b0;
        end
        if (el == 4 * S) m_busy = 1'b0;
      end
      if ((m_seln && m_selx) && (!armed_pre || clr)) wd_ref = cyc;
      hq = {hq[1:0], xclk_hb};
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, xclk_fault} !==
          {m_seln, m_selx, m_selr, m_div, !m_busy, m_busy, m_fault}) begin
        n_errors++;
        $display("FAIL model_cmp cyc=%0d: got seln=%b selx=%b rosc=%0d div=%0d rdy=%b busy=%b flt=%b, expected seln=%b selx=%b rosc=%0d div=%0d rdy=%b busy=%b flt=%b",
                 cyc, sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, xclk_fault,
                 m_seln, m_selx, m_selr, m_div, !m_busy, m_busy, m_fault);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a request; returns just after the accepting edge.
  task automatic request(input logic [1:0] src, input logic [1:0] rosc, input logic [1:0] dv);
    req_valid = 1'b1;
    req_src = src;
    req_rosc = rosc;
    req_div = dv;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seln"}, 32'(sel_n_8mhz), 32'd0);
    check({tag, "_selx"}, 32'(sel_xclk), 32'd0);
    check({tag, "_selr"}, 32'(sel_rosc), 32'd0);
    check({tag, "_div"}, 32'(clk_div), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fault"}, 32'(xclk_fault), 32'd0);
  endtask

  // Free-running heartbeat: toggles every 8 cycles while enabled.
  initial begin
    forever begin
      repeat (8) @(posedge clk);
      #1;
      if (hb_en) xclk_hb = ~xclk_hb;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int hb_cnt;
    bit hb_alive;
    step(1);
    chk_en = 1'b1;
    step(2);
    check_reset_vals("rst");
    rst = 1'b0;
    step(1);
    check_reset_vals("rst_rel");

    // xclk switch
    hb_en = 1'b1;
    request(2'd1, 2'd0, 2'd0);
    check("x_ready_drop", 32'(req_ready), 32'd0);
    check("x_busy", 32'(busy), 32'd1);
    step(15);
    check("x_selx_early", 32'(sel_xclk), 32'd0);
    step(1);
    check("x_selx", 32'(sel_xclk), 32'd1);
    step(15);
    check("x_seln_early", 32'(sel_n_8mhz), 32'd0);
    step(1);
    check("x_seln", 32'(sel_n_8mhz), 32'd1);
    step(31);
    check("x_ready_early", 32'(req_ready), 32'd0);
    step(1);
    check("x_ready", 32'(req_ready), 32'd1);

    // rosc switch from xclk
    request(2'd2, 2'd3, 2'd2);
    check("r_seln_fall", 32'(sel_n_8mhz), 32'd0);
    check("r_selx_hold", 32'(sel_xclk), 32'd1);
    step(15);
    check("r_mux_hold", 32'({sel_xclk, sel_rosc}), 32'h4);
    step(1);
    check("r_mux", 32'({sel_n_8mhz, sel_xclk, sel_rosc}), 32'h3);
    step(16);
    check("r_switch", 32'({sel_n_8mhz, sel_xclk, sel_rosc, clk_div}), 32'h2C);
    step(16);
    check("r_div", 32'({sel_n_8mhz, sel_xclk, sel_rosc, clk_div}), 32'h2E);
    step(16);
    check("r_ready", 32'(req_ready), 32'd1);

    // back to xclk, then heartbeat loss
    request(2'd1, 2'd0, 2'd2);
    step(64);
    check("l_on_xclk", 32'({sel_n_8mhz, sel_xclk, req_ready}), 32'h7);
    hb_en = 1'b0;
    step(1);
    xclk_hb = ~xclk_hb;
    step(66);
    check("l_fault_early", 32'(xclk_fault), 32'd0);
    step(1);
    check("l_fault", 32'(xclk_fault), 32'd1);
    check("l_fallback", 32'({sel_n_8mhz, sel_xclk}), 32'd0);
    check("l_div_kept", 32'(clk_div), 32'd2);

    // interlock, clear, retry
    request(2'd1, 2'd0, 2'd1);
    step(47);
    check("i_ready_early", 32'(req_ready), 32'd0);
    step(1);
    check("i_ready", 32'(req_ready), 32'd1);
    check("i_on_8m", 32'({sel_n_8mhz, sel_xclk, clk_div}), 32'd1);
    check("i_fault_sticky", 32'(xclk_fault), 32'd1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("i_fault_clr", 32'(xclk_fault), 32'd0);
    hb_en = 1'b1;
    request(2'd1, 2'd0, 2'd1);
    step(64);
    check("i_retry", 32'({sel_n_8mhz, sel_xclk, req_ready}), 32'h7);

    // reset in the MUX step
    request(2'd2, 2'd1, 2'd3);
    step(20);
    rst = 1'b1;
    step(1);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    hb_en = 1'b0;
    step(2);

    // randomized traffic
    hb_alive = 1'b1;
    hb_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_src = 2'($urandom);
      req_rosc = 2'($urandom);
      req_div = 2'($urandom);
      fault_clr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) hb_alive = !hb_alive;
      if (hb_alive) begin
        if (hb_cnt == 0) begin
          xclk_hb = ~xclk_hb;
          hb_cnt = $urandom_range(1, 20);
        end else begin
          hb_cnt--;
        end
      end
      step(1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    fault_clr = 1'b0;
    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
